// File: rtl/qam_pkg.sv
// Shared QAM constants, framer state encoding and Gray helper.
// Used by the symbol framer and the downstream modulator.
package qam_pkg;

  localparam int QAM_WIDTH  = 4;
  localparam int WAVE_WIDTH = 12;

  typedef enum logic {
    IDLE,
    HOLD
  } framer_state_t;

  function automatic logic [31:0] gray_encode(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO with occupancy level.
// Callers never push when full nor pop when empty.
module sym_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_framer.sv
// Serial-to-symbol packer with FIFO and fixed symbol hold.
// Feeds the QAM modulator data_in directly from data_out.
module qam_symbol_framer
  import qam_pkg::*;
#(
  parameter int QAM_WIDTH     = qam_pkg::QAM_WIDTH,
  parameter int SYMBOL_PERIOD = 1000,
  parameter int FIFO_DEPTH    = 4,
  parameter int GRAY_EN       = 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int CW = $clog2(SYMBOL_PERIOD + 1),
  localparam int BW = (QAM_WIDTH > 1) ? $clog2(QAM_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [QAM_WIDTH-1:0] data_out,
  output logic                 sym_strobe,
  output logic                 sym_active,
  output logic [LW-1:0]        fifo_level,
  output logic                 underrun,
  input  logic                 underrun_clr
);

  logic [BW-1:0]        bit_cnt;
  logic [QAM_WIDTH-1:0] shreg;
  logic [QAM_WIDTH-1:0] word;
  logic [QAM_WIDTH-1:0] sym;
  logic [QAM_WIDTH-1:0] fifo_dout;
  logic                 last_bit;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  framer_state_t        state;
  framer_state_t        state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [QAM_WIDTH-1:0] dout_n;
  logic                 strobe_n;
  logic                 active_n;
  logic                 under_set;

  // readiness uses registered full only: no pop-through
  assign last_bit  = (bit_cnt == BW'(QAM_WIDTH - 1));
  assign bit_ready = reset && !(last_bit && full);
  assign accept    = bit_valid && bit_ready;
  assign push      = accept && last_bit;
  assign word      = QAM_WIDTH'({shreg, bit_in});
  assign sym       = (GRAY_EN != 0)
                   ? QAM_WIDTH'(gray_encode(32'(word)))
                   : word;

  // first bit received ends up as the symbol MSB
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (accept) begin
      shreg   <= word;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  sym_fifo #(
    .WIDTH (QAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sym),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // next-state and output decode for symbol pacing
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dout_n    = data_out;
    strobe_n  = 1'b0;
    active_n  = sym_active;
    under_set = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        active_n = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          dout_n   = fifo_dout;
          strobe_n = 1'b1;
          cnt_n    = '0;
          active_n = 1'b1;
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if (cnt == CW'(SYMBOL_PERIOD - 1)) begin
          if (!empty) begin
            pop      = 1'b1;
            dout_n   = fifo_dout;
            strobe_n = 1'b1;
            cnt_n    = '0;
          end else begin
            state_n   = IDLE;
            active_n  = 1'b0;
            under_set = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // registered FSM state and outputs; underrun set beats clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      data_out   <= '0;
      sym_strobe <= 1'b0;
      sym_active <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_out   <= dout_n;
      sym_strobe <= strobe_n;
      sym_active <= active_n;
      underrun   <= under_set | (underrun & ~underrun_clr);
    end
  end

endmodule

// File: tb/tb_qam_symbol_framer.sv
// Bench for qam_symbol_framer: three configured instances
// checked against a queue-based symbol model.
module tb_qam_symbol_framer;

  logic       clk = 1'b0;
  logic       rst  [3];
  logic       bv   [3];
  logic       bi   [3];
  logic       clr  [3];
  logic       rdy  [3];
  logic       strb [3];
  logic       act  [3];
  logic       und  [3];
  logic [3:0] dout [3];
  logic [2:0] lvl  [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] q [3][$];
  int         run    [3];
  int         maxl   [3];
  int         stalls [3];
  bit         was    [3];

  always #5 clk = ~clk;

  qam_symbol_framer #(
    .QAM_WIDTH(4), .SYMBOL_PERIOD(4),
    .FIFO_DEPTH(4), .GRAY_EN(0)
  ) u_plain (
    .clk(clk), .reset(rst[0]),
    .bit_in(bi[0]), .bit_valid(bv[0]),
    .bit_ready(rdy[0]), .data_out(dout[0]),
    .sym_strobe(strb[0]), .sym_active(act[0]),
    .fifo_level(lvl[0]), .underrun(und[0]),
    .underrun_clr(clr[0])
  );

  qam_symbol_framer #(
    .QAM_WIDTH(4), .SYMBOL_PERIOD(16),
    .FIFO_DEPTH(4), .GRAY_EN(1)
  ) u_gray (
    .clk(clk), .reset(rst[1]),
    .bit_in(bi[1]), .bit_valid(bv[1]),
    .bit_ready(rdy[1]), .data_out(dout[1]),
    .sym_strobe(strb[1]), .sym_active(act[1]),
    .fifo_level(lvl[1]), .underrun(und[1]),
    .underrun_clr(clr[1])
  );

  qam_symbol_framer #(
    .QAM_WIDTH(4), .SYMBOL_PERIOD(1),
    .FIFO_DEPTH(4), .GRAY_EN(0)
  ) u_fast (
    .clk(clk), .reset(rst[2]),
    .bit_in(bi[2]), .bit_valid(bv[2]),
    .bit_ready(rdy[2]), .data_out(dout[2]),
    .sym_strobe(strb[2]), .sym_active(act[2]),
    .fifo_level(lvl[2]), .underrun(und[2]),
    .underrun_clr(clr[2])
  );

  function automatic int per(int i);
    if (i == 0) return 4;
    if (i == 1) return 16;
    return 1;
  endfunction

  function automatic logic [3:0] model_sym(int i, logic [3:0] w);
    if (i == 1) return w ^ (w >> 1);
    return w;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // symbol order and hold-length monitor, just after each edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) begin
        run[i] = 0;
        was[i] = 1'b0;
      end else begin
        if (strb[i]) begin
          logic [4:0] e;
          if (was[i]) chk($sformatf("hold_%0d", i), run[i], per(i));
          e = (q[i].size() != 0) ? {1'b0, q[i].pop_front()} : 5'h1f;
          chk($sformatf("sym_%0d", i), {1'b0, dout[i]}, e);
          run[i] = 1;
        end else if (act[i]) begin
          run[i]++;
        end else if (was[i]) begin
          chk($sformatf("hold_end_%0d", i), run[i], per(i));
          run[i] = 0;
        end
        if (int'(lvl[i]) > maxl[i]) maxl[i] = int'(lvl[i]);
        was[i] = act[i];
      end
    end
  end

  task automatic send_word(int i, logic [3:0] w, int gap);
    int g;
    for (int b = 3; b >= 0; b--) begin
      if (gap > 0) begin
        bv[i] = 1'b0;
        repeat ($urandom_range(0, gap)) @(negedge clk);
      end
      bi[i] = w[b];
      bv[i] = 1'b1;
      g = 0;
      if (!rdy[i]) begin
        stalls[i]++;
        chk("stall_at_last_bit", b, 0);
      end
      while (!rdy[i] && g < 5000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 5000) chk("ready_timeout", g, 0);
      @(negedge clk);
      if (b == 0) q[i].push_back(model_sym(i, w));
    end
    bv[i] = 1'b0;
  endtask

  task automatic wait_drain(int i);
    int g = 0;
    while ((q[i].size() != 0 || act[i]) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("drain_%0d", i), g < 3000, 1);
  endtask

  task automatic chk_reset_vals(int i);
    chk("rst_data", dout[i], 0);
    chk("rst_strobe", strb[i], 0);
    chk("rst_active", act[i], 0);
    chk("rst_underrun", und[i], 0);
    chk("rst_level", lvl[i], 0);
    chk("rst_ready", rdy[i], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w;
    int g;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; bv[i] = 1'b0;
      bi[i] = 1'b0;  clr[i] = 1'b0;
      run[i] = 0; maxl[i] = 0; stalls[i] = 0;
      was[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_vals(i);
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", rdy[0], 1);

    // directed: 1,0,1,1 -> 1011 two edges after last accept
    send_word(0, 4'b1011, 0);
    chk("lat_no_strobe_yet", strb[0], 0);
    @(negedge clk);
    chk("lat_data", dout[0], 4'b1011);
    chk("lat_strobe", strb[0], 1);
    chk("lat_active", act[0], 1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_strobe_low", strb[0], 0);
      chk("hold_data", dout[0], 4'b1011);
      chk("hold_active", act[0], 1);
    end
    @(negedge clk);
    chk("expire_active", act[0], 0);
    chk("expire_underrun", und[0], 1);
    chk("expire_data_kept", dout[0], 4'b1011);

    // clear coincides with a new underrun: set wins
    send_word(0, 4'b0101, 0);
    repeat (4) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("set_wins_underrun", und[0], 1);
    chk("set_wins_active", act[0], 0);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("clear_alone", und[0], 0);

    // random words with random gaps
    repeat (12) send_word(0, 4'($urandom), 3);
    wait_drain(0);

    // gray stream 0..15 with backpressure
    for (int k = 0; k < 16; k++) send_word(1, 4'(k), 0);
    g = 0;
    while (q[1].size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("gray_q_empty", g < 1000, 1);
    chk("gray_no_underrun", und[1], 0);
    chk("gray_active", act[1], 1);
    wait_drain(1);
    chk("gray_underrun_end", und[1], 1);
    chk("gray_max_level", maxl[1], 4);
    chk("gray_stall_seen", stalls[1] > 0, 1);

    // reset mid-word with two words queued
    send_word(1, 4'd3, 0);
    send_word(1, 4'd5, 0);
    send_word(1, 4'd9, 0);
    chk("queued_level", lvl[1], 2);
    bv[1] = 1'b1; bi[1] = 1'b0;
    @(negedge clk);
    bi[1] = 1'b1;
    @(negedge clk);
    bv[1] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk_reset_vals(1);
    rst[1] = 1'b1;
    q[1].delete();
    @(negedge clk);
    chk("post_rst_level", lvl[1], 0);
    send_word(1, 4'b0110, 0);
    @(negedge clk);
    chk("post_rst_data", dout[1], 4'b0101);
    chk("post_rst_strobe", strb[1], 1);
    wait_drain(1);
    chk("post_rst_empty", lvl[1], 0);

    // one-clock symbols
    for (int k = 0; k < 3; k++) begin
      w = 4'($urandom);
      send_word(2, w, 0);
      @(negedge clk);
      chk("fast_data", dout[2], w);
      chk("fast_strobe", strb[2], 1);
      @(negedge clk);
      chk("fast_idle", act[2], 0);
    end
    chk("fast_underrun", und[2], 1);
    wait_drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
